// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the push-button front-end
// Contents:
//   key_state_e  : one-hot per-channel debounce/long-press state
//   KEY_RELEASED : synchronised level of a key that is not pressed (keys are active-low)
//   cnt_width()  : counter width covering the longer of the long-press and repeat periods
package key_pkg;

    typedef enum logic [4:0] {
        IDLE     = 5'b00001,
        PRESS_DB = 5'b00010,
        PRESSED  = 5'b00100,
        HOLD     = 5'b01000,
        REL_DB   = 5'b10000
    } key_state_e;

    localparam logic KEY_RELEASED = 1'b1;

    function automatic int cnt_width(input int long_cnt, input int repeat_cnt);
        int m;
        m = (long_cnt > repeat_cnt) ? long_cnt : repeat_cnt;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_pulse_gen_if.sv
// rtl/key_pulse_gen_if.sv - key bundle between the raw buttons and their consumers
// Signals (all KEY_NUM wide):
//   key_in    : raw active-low keys (driven by the board side / master)
//   key_pulse : one-cycle press strobe per key
//   key_level : debounced pressed level (1 = pressed)
//   key_long  : long-press flag
// Modports: master drives key_in and observes the rest; slave is the debouncer.
interface key_pulse_gen_if #(
    parameter int KEY_NUM = 3
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_pulse;
    logic [KEY_NUM-1:0] key_level;
    logic [KEY_NUM-1:0] key_long;

    modport master (output key_in, input key_pulse, input key_level, input key_long);
    modport slave  (input key_in, output key_pulse, output key_level, output key_long);
endinterface

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: 2-FF synchroniser, debounce/long-press FSM, counter
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   key_raw_i     : raw asynchronous active-low key
//   key_pulse_o   : one-cycle press strobe (also on each auto-repeat wrap)
//   key_level_o   : debounced pressed level
//   key_long_o    : high while held beyond LONG_CNT
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat pulses while in HOLD).
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CNT = 20000,
    parameter int LONG_CNT     = 1000000,
    parameter int REPEAT_CNT   = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_i,
    output logic key_pulse_o,
    output logic key_level_o,
    output logic key_long_o
);

    localparam int CW = cnt_width(LONG_CNT, REPEAT_CNT);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);
`ifdef KEY_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CNT - 1);
`endif

    logic          sync1_q;
    logic          sync2_q;
    key_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          pulse_q;
    logic          level_q;
    logic          long_q;
    logic          released;

    // Synchroniser resets to "released" so a held key after reset is seen as a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= KEY_RELEASED;
            sync2_q <= KEY_RELEASED;
        end else begin
            sync1_q <= key_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign released = (sync2_q == KEY_RELEASED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!released) begin
                        state_q <= PRESS_DB;
                        cnt_q   <= '0;
                    end
                end
                PRESS_DB: begin
                    if (released) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        pulse_q <= 1'b1;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (released) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= HOLD;
                        cnt_q   <= '0;
                        long_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (released) begin
                        state_q <= REL_DB;
                        cnt_q   <= '0;
                        long_q  <= 1'b0;
                    end else begin
`ifdef KEY_AUTO_REPEAT_EN
                        if (cnt_q == REP_LAST) begin
                            cnt_q   <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
`else
                        cnt_q <= '0;
`endif
                    end
                end
                REL_DB: begin
                    // A re-press during release debounce is a glitch: back to PRESSED
                    // without a pulse, and the long-press timer starts over.
                    if (!released) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign key_pulse_o = pulse_q;
    assign key_level_o = level_q;
    assign key_long_o  = long_q;

endmodule

// File: rtl/key_pulse_gen.sv
// rtl/key_pulse_gen.sv - synchronise and debounce KEY_NUM push-buttons into pulses/levels/long flags
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : key_pulse_gen_if.slave (key_in in; key_pulse, key_level, key_long out)
// key_pulse[0] feeds the setting-mode enable; key_pulse[1]/[2] are the up/down strobes.
// Optional feature macro: KEY_AUTO_REPEAT_EN (auto-repeat while a key is held long).
module key_pulse_gen #(
    parameter int KEY_NUM      = 3,
    parameter int DEBOUNCE_CNT = 20000,
    parameter int LONG_CNT     = 1000000,
    parameter int REPEAT_CNT   = 200000
) (
    input logic              clk,
    input logic              rst_n,
    key_pulse_gen_if.slave   bus
);

    logic [KEY_NUM-1:0] pulse_w;
    logic [KEY_NUM-1:0] level_w;
    logic [KEY_NUM-1:0] long_w;

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT),
            .LONG_CNT     (LONG_CNT),
            .REPEAT_CNT   (REPEAT_CNT)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_raw_i   (bus.key_in[i]),
            .key_pulse_o (pulse_w[i]),
            .key_level_o (level_w[i]),
            .key_long_o  (long_w[i])
        );
    end

    assign bus.key_pulse = pulse_w;
    assign bus.key_level = level_w;
    assign bus.key_long  = long_w;

endmodule
